// File: rtl/ripple_seq_pkg.sv
// ripple_seq_pkg
//   Shared constants and FSM encoding for the nibble-serial ripple adder
//   sequencer (ripple_add_sequencer) and its nibble adder (nibble_adder4).
//   Contents:
//     NIBBLE_W      width of the shared adder slice (4 bits)
//     state_t       2-bit FSM state type
//     IDLE/RUN/DONE state encodings 2'd0 / 2'd1 / 2'd2
package ripple_seq_pkg;

    localparam int NIBBLE_W = 4;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

endpackage

// File: rtl/ripple_add_sequencer_nibble_adder4.sv
// nibble_adder4
//   Combinational 4-bit ripple-carry adder slice. Each bit produces its sum
//   and passes a carry to the next bit, so the carry ripples LSB to MSB.
//   Ports:
//     a    in  [3:0]  addend nibble
//     b    in  [3:0]  addend nibble
//     cin  in  1      carry into bit 0
//     s    out [3:0]  sum nibble
//     cout out 1      carry out of bit 3
module nibble_adder4
    import ripple_seq_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] s,
    output logic                cout
);

    logic [NIBBLE_W:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < NIBBLE_W; i++) begin
            s[i]     = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[NIBBLE_W];
    end

endmodule

// File: rtl/ripple_add_sequencer.sv
// ripple_add_sequencer
//   Adds two WIDTH-bit operands with a single shared 4-bit ripple adder,
//   one nibble per clock, least significant nibble first. The carry between
//   nibbles is held in carry_reg. Valid/ready handshakes on both sides.
//   Optional feature macro: RIPPLE_SEQ_SUB_EN adds the `sub` port; with sub=1
//   at accept the block computes a-b (B stored inverted, carry-in forced to 1)
//   and cout=1 means no borrow.
//   Ports:
//     clk        in   1      clock, rising edge
//     rst        in   1      synchronous reset, active-high
//     in_valid   in   1      operands valid
//     in_ready   out  1      accepting operands (IDLE)
//     a, b       in   WIDTH  operands
//     cin        in   1      carry into nibble 0
//     sub        in   1      subtract select (RIPPLE_SEQ_SUB_EN only)
//     out_valid  out  1      result valid (DONE)
//     out_ready  in   1      consumer takes result
//     sum        out  WIDTH  result
//     cout       out  1      carry out of the top nibble
//     busy       out  1      RUN or DONE
module ripple_add_sequencer
    import ripple_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef RIPPLE_SEQ_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    state_t                state;
    logic [IDX_W-1:0]      idx;
    logic                  carry_reg;
    logic [WIDTH-1:0]      a_reg;
    logic [WIDTH-1:0]      b_reg;

    logic [WIDTH-1:0]      b_load;
    logic                  c_load;
    logic [NIBBLE_W-1:0]   nib_a;
    logic [NIBBLE_W-1:0]   nib_b;
    logic [NIBBLE_W-1:0]   nib_s;
    logic                  nib_c;
    logic                  accept;

    // Subtraction is a + ~b + 1, so only the loaded B value and the initial
    // carry differ from the add path.
`ifdef RIPPLE_SEQ_SUB_EN
    assign b_load = sub ? ~b : b;
    assign c_load = sub ? 1'b1 : cin;
`else
    assign b_load = b;
    assign c_load = cin;
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign accept    = in_valid && in_ready;

    assign nib_a = a_reg[NIBBLE_W*int'(idx) +: NIBBLE_W];
    assign nib_b = b_reg[NIBBLE_W*int'(idx) +: NIBBLE_W];

    nibble_adder4 u_add (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_reg),
        .s    (nib_s),
        .cout (nib_c)
    );

    // Operand capture: pure data, loaded only on accept, never reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_reg <= a;
            b_reg <= b_load;
        end
    end

    // Control and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            carry_reg <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        carry_reg <= c_load;
                        idx       <= '0;
                        sum       <= '0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    sum[NIBBLE_W*int'(idx) +: NIBBLE_W] <= nib_s;
                    carry_reg <= nib_c;
                    // idx parks on the last nibble instead of wrapping.
                    if (idx == LAST_IDX) begin
                        cout  <= nib_c;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ripple_add_sequencer.sv
module tb_ripple_add_sequencer;

    logic        clk = 1'b0;
    logic        rst;

    logic        in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
    logic [15:0] a, b, sum;

    logic        in_valid4, in_ready4, cin4, out_valid4, out_ready4, cout4, busy4;
    logic [3:0]  a4, b4, sum4;

`ifdef RIPPLE_SEQ_SUB_EN
    logic        sub, sub4;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ripple_add_sequencer #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
`ifdef RIPPLE_SEQ_SUB_EN
        .sub(sub),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .busy(busy)
    );

    ripple_add_sequencer #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .cin(cin4),
`ifdef RIPPLE_SEQ_SUB_EN
        .sub(sub4),
`endif
        .out_valid(out_valid4), .out_ready(out_ready4), .sum(sum4), .cout(cout4), .busy(busy4)
    );

    // Drives one operation on the 16-bit DUT and returns what it produced.
    // Operands are scrambled right after accept to show they are registered.
    task automatic run_op(input logic [15:0] ai, input logic [15:0] bi, input logic ci,
                          input logic si, output logic [15:0] so, output logic co, output int lat);
        int guard;
        @(posedge clk); #1;
        a = ai; b = bi; cin = ci; in_valid = 1'b1;
`ifdef RIPPLE_SEQ_SUB_EN
        sub = si;
`else
        if (si) $display("note: sub requested without subtract support");
`endif
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        so = sum; co = cout;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (sum !== 16'h0) begin bad++; $display("FAIL reset_sum got=%h want=0000", sum); end
        total++; if (cout !== 1'b0) begin bad++; $display("FAIL reset_cout got=%b want=0", cout); end
        total++; if (in_ready4 !== 1'b1) begin bad++; $display("FAIL reset_in_ready4 got=%b want=1", in_ready4); end
        rst = 1'b0;
    endtask

    task automatic test_vectors();
        logic [15:0] s; logic c; int lat;
        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, s, c, lat);
        total++; if (s !== 16'h5555) begin bad++; $display("FAIL basic_sum got=%h want=5555", s); end
        total++; if (c !== 1'b0) begin bad++; $display("FAIL basic_cout got=%b want=0", c); end
        total++; if (lat !== 4) begin bad++; $display("FAIL basic_latency got=%0d want=4", lat); end
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, s, c, lat);
        total++; if (s !== 16'h0000) begin bad++; $display("FAIL chain_sum got=%h want=0000", s); end
        total++; if (c !== 1'b1) begin bad++; $display("FAIL chain_cout got=%b want=1", c); end
        run_op(16'h0000, 16'h0000, 1'b1, 1'b0, s, c, lat);
        total++; if (s !== 16'h0001) begin bad++; $display("FAIL cin_sum got=%h want=0001", s); end
        total++; if (c !== 1'b0) begin bad++; $display("FAIL cin_cout got=%b want=0", c); end
    endtask

    task automatic test_random();
        logic [15:0] ai, bi, s; logic ci, c; int lat; logic [16:0] exp;
        for (int i = 0; i < 25; i++) begin
            ai = 16'($urandom); bi = 16'($urandom); ci = 1'($urandom);
            if (i == 0) begin ai = 16'hFFFF; bi = 16'hFFFF; ci = 1'b1; end
            exp = {1'b0, ai} + {1'b0, bi} + 17'(ci);
            run_op(ai, bi, ci, 1'b0, s, c, lat);
            total++; if (s !== exp[15:0] || c !== exp[16] || lat !== 4) begin
                bad++; $display("FAIL random_op %h+%h+%b got=%b_%h lat=%0d want=%b_%h lat=4", ai, bi, ci, c, s, lat, exp[16], exp[15:0]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] s0; logic c0; int lat;
        @(posedge clk); #1;
        a = 16'hA5A5; b = 16'h5A5A; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        s0 = sum; c0 = cout;
        total++; if (s0 !== 16'h0000 || c0 !== 1'b1) begin bad++; $display("FAIL bp_first got=%b_%h want=1_0000", c0, s0); end
        a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total++; if (out_valid !== 1'b1 || sum !== 16'h0000 || cout !== 1'b1 || in_ready !== 1'b0) begin
                bad++; $display("FAIL bp_hold cyc=%0d got ov=%b sum=%h cout=%b ir=%b want ov=1 sum=0000 cout=1 ir=0", i, out_valid, sum, cout, in_ready);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL bp_release got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++; if (busy !== 1'b1 || in_ready !== 1'b0) begin
            bad++; $display("FAIL bp_accept got busy=%b ir=%b want busy=1 ir=0", busy, in_ready);
        end
        lat = 0;
        while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        total++; if (sum !== 16'h3333 || cout !== 1'b0 || lat !== 4) begin
            bad++; $display("FAIL bp_second got=%b_%h lat=%0d want=0_3333 lat=4", cout, sum, lat);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        logic [15:0] s; logic c; int lat;
        @(posedge clk); #1;
        a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || sum !== 16'h0) begin
            bad++; $display("FAIL midrun_reset got ov=%b ir=%b busy=%b sum=%h want ov=0 ir=1 busy=0 sum=0000", out_valid, in_ready, busy, sum);
        end
        run_op(16'h0F0F, 16'h0101, 1'b0, 1'b0, s, c, lat);
        total++; if (s !== 16'h1010 || c !== 1'b0) begin bad++; $display("FAIL after_reset_add got=%b_%h want=0_1010", c, s); end
    endtask

`ifdef RIPPLE_SEQ_SUB_EN
    task automatic test_sub();
        logic [15:0] ai, bi, s; logic c; int lat;
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, s, c, lat);
        total++; if (s !== 16'hFFFE || c !== 1'b0) begin bad++; $display("FAIL sub_borrow got=%b_%h want=0_fffe", c, s); end
        run_op(16'h0007, 16'h0005, 1'b1, 1'b1, s, c, lat);
        total++; if (s !== 16'h0002 || c !== 1'b1) begin bad++; $display("FAIL sub_noborrow got=%b_%h want=1_0002", c, s); end
        for (int i = 0; i < 8; i++) begin
            ai = 16'($urandom); bi = 16'($urandom);
            run_op(ai, bi, 1'($urandom), 1'b1, s, c, lat);
            total++; if (s !== 16'(ai - bi) || c !== (ai >= bi)) begin
                bad++; $display("FAIL sub_random %h-%h got=%b_%h want=%b_%h", ai, bi, c, s, (ai >= bi), 16'(ai - bi));
            end
        end
        sub = 1'b0;
    endtask
`endif

    task automatic test_width4();
        logic [3:0] ai, bi; logic ci; logic [4:0] exp; int lat;
        for (int i = 0; i < 10; i++) begin
            if (i == 0) begin ai = 4'h9; bi = 4'h8; ci = 1'b1; end
            else begin ai = 4'($urandom); bi = 4'($urandom); ci = 1'($urandom); end
            exp = {1'b0, ai} + {1'b0, bi} + 5'(ci);
            @(posedge clk); #1;
            a4 = ai; b4 = bi; cin4 = ci; in_valid4 = 1'b1;
            total++; if (in_ready4 !== 1'b1) begin bad++; $display("FAIL w4_ready got=%b want=1", in_ready4); end
            @(posedge clk); #1;
            in_valid4 = 1'b0;
            lat = 0;
            while (!out_valid4 && lat < 20) begin @(posedge clk); #1; lat++; end
            total++; if (sum4 !== exp[3:0] || cout4 !== exp[4] || lat !== 1) begin
                bad++; $display("FAIL w4_op %h+%h+%b got=%b_%h lat=%0d want=%b_%h lat=1", ai, bi, ci, cout4, sum4, lat, exp[4], exp[3:0]);
            end
            out_ready4 = 1'b1;
            @(posedge clk); #1;
            out_ready4 = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
`ifdef RIPPLE_SEQ_SUB_EN
        sub = 1'b0; sub4 = 1'b0;
`endif
        test_reset();
        test_vectors();
        test_random();
        test_backpressure();
        test_reset_mid_run();
`ifdef RIPPLE_SEQ_SUB_EN
        test_sub();
`endif
        test_width4();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
